// File: rtl/hdsiso_pkg.sv
// Shared types and constants for the HD-SISO phase sequencer.
package hdsiso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int PHASES = 8;
    localparam int PH_W   = 3;
    localparam int GAP_W  = 4;

    // x^15 + x^14 + 1, Fibonacci form: feedback = q[14] ^ q[13]
    localparam int                LFSR_W        = 15;
    localparam int                TAP_HI        = 14;
    localparam int                TAP_LO        = 13;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 15'h0001;

    function automatic logic [PH_W-1:0] bin2gray(input logic [PH_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/hdsiso_lfsr15.sv
// 15-bit Fibonacci LFSR with a one-cycle strobe when an advance lands on SEED.
module hdsiso_lfsr15
    import hdsiso_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv_i,
    output logic bit_o,
    output logic nxt_bit_o,
    output logic at_seed_o
);

    logic [LFSR_W-1:0] q_q, q_d;
    logic              at_seed_q, at_seed_d;

    // Next state: shift left, feed back the tap XOR; hold when not advancing
    always_comb begin
        q_d       = q_q;
        at_seed_d = 1'b0;
        if (adv_i) begin
            q_d       = {q_q[LFSR_W-2:0], q_q[TAP_HI] ^ q_q[TAP_LO]};
            at_seed_d = (q_d == SEED);
        end
    end

    // LFSR state and period strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= SEED;
            at_seed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            at_seed_q <= at_seed_d;
        end
    end

    assign bit_o     = q_q[LFSR_W-1];
    // Bit as it will be after this cycle's (possible) advance; lets the
    // sequencer load the post-advance bit on the same edge.
    assign nxt_bit_o = q_d[LFSR_W-1];
    assign at_seed_o = at_seed_q;

endmodule

// File: rtl/hdsiso_phase_seq.sv
// Reverse-order (7..0) non-overlapping stage pulse sequencer for the SISO
// latch array, with Gray phase output and serial data source selection.
module hdsiso_phase_seq
    import hdsiso_pkg::*;
#(
    parameter int                GAP_CYCLES = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              lfsr_en,
    input  logic              din_sel,
    input  logic              d_in,
    output logic [PHASES-1:0] pulse,
    output logic [PH_W-1:0]   gray,
    output logic              d_src,
    output logic              shift_done,
    output logic              lfsr_bit,
    output logic              lfsr_period
);

    localparam bit               HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);
    localparam logic [PH_W-1:0]  P_LAST   = PH_W'(PHASES - 1);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   p_q, p_d;
    logic [GAP_W-1:0]  gcnt_q, gcnt_d;
    logic              step_en, eos, load_src, adv, nxt_bit;
    logic              d_src_q, d_src_d;
    logic [PHASES-1:0] pulse_q, pulse_d;
    logic [PH_W-1:0]   gray_q;
    logic              sd_q, sd_d;

    hdsiso_lfsr15 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv_i     (adv),
        .bit_o     (lfsr_bit),
        .nxt_bit_o (nxt_bit),
        .at_seed_o (lfsr_period)
    );

    // Next-state: phase/gap counting, end-of-shift detection, run sampling
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        gcnt_d   = gcnt_q;
        step_en  = 1'b0;
        eos      = 1'b0;
        load_src = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d  = PULSE;
                    p_d      = '0;
                    load_src = 1'b1;
                end
            end
            PULSE: begin
                if (HAS_GAP) begin
                    state_d = GAP;
                    gcnt_d  = '0;
                end else begin
                    step_en = 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == GAP_LAST) step_en = 1'b1;
                else                    gcnt_d  = gcnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (step_en) begin
            if (p_q != P_LAST) begin
                p_d     = p_q + 3'd1;
                state_d = PULSE;
            end else begin
                // run is only looked at here and in IDLE, so a shift never truncates
                eos      = 1'b1;
                p_d      = '0;
                state_d  = run ? PULSE : IDLE;
                load_src = run;
            end
        end
    end

    assign adv     = eos & lfsr_en;
    // nxt_bit already reflects this edge's advance, so a reload sees the new bit
    assign d_src_d = load_src ? (din_sel ? nxt_bit : d_in) : d_src_q;

    // Output decode from next state so pulse/shift_done come straight from flops
    always_comb begin
        pulse_d = '0;
        if (state_d == PULSE) pulse_d = 8'h80 >> p_d;
        sd_d = (p_d == P_LAST) &&
               ((!HAS_GAP && state_d == PULSE) ||
                ( HAS_GAP && state_d == GAP && gcnt_d == GAP_LAST));
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            gcnt_q  <= '0;
            d_src_q <= 1'b0;
            pulse_q <= '0;
            gray_q  <= '0;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            gcnt_q  <= gcnt_d;
            d_src_q <= d_src_d;
            pulse_q <= pulse_d;
            gray_q  <= bin2gray(p_d);
            sd_q    <= sd_d;
        end
    end

    assign pulse      = pulse_q;
    assign gray       = gray_q;
    assign d_src      = d_src_q;
    assign shift_done = sd_q;

endmodule

// File: doc/hdsiso_phase_seq.md
# hdsiso_phase_seq

Phase sequencer for the 8‑stage high‑density SISO shift register. It generates the eight non‑overlapping stage pulses in reverse stage order (7 down to 0), so each stage captures its predecessor before that predecessor is overwritten. It exposes the phase as a 3‑bit Gray code and selects the serial data source (external pin or internal LFSR). It sits between the clock/reset selection logic and the SISO latch array inside tt_um_ygdes_hdsiso8.

## Interface
- GAP_CYCLES, 1: all‑low cycles inserted after every pulse; legal range 0..15.
- LFSR_SEED, 15'h0001: reset and period‑reference state of the LFSR; must be non‑zero.

- clk  in  1  sequencer clock (selected internal or external clock)
- rst_n  in  1  reset; one clock, asynchronous assertion, active‑low
- run  in  1  level; while high, shifts repeat back to back
- lfsr_en  in  1  allow LFSR to advance at the end of each shift
- din_sel  in  1  data source select: 0 = d_in, 1 = lfsr_bit
- d_in  in  1  external serial data
- pulse  out  8  one‑hot stage enables for the SISO latches
- gray  out  3  Gray code of the current phase index
- d_src  out  1  serial data presented to stage 0, held for a whole shift
- shift_done  out  1  one‑cycle strobe when a shift completes
- lfsr_bit  out  1  LFSR bit q[14]
- lfsr_period  out  1  one‑cycle strobe when the LFSR re‑enters LFSR_SEED

## Operation
- States: IDLE, PULSE, GAP.
- Phase counter p: 3 bits, 0..7. pulse[7‑p] is high only in PULSE. gray = p ^ (p>>1).
- IDLE → PULSE (p=0) when run=1. On this transition, d_src loads (din_sel ? lfsr_bit : d_in).
- PULSE → GAP when GAP_CYCLES>0. Otherwise PULSE goes directly to the next step.
- GAP lasts exactly GAP_CYCLES cycles, counted by a 4‑bit counter, then the next step.
- Next step when p<7: p increments and the state is PULSE.
- Next step when p=7 (end of shift):
  - shift_done=1 for one cycle.
  - LFSR advances if lfsr_en=1.
  - If run=1: p←0, state PULSE, and d_src reloads from the advanced LFSR or d_in.
  - If run=0: state IDLE, p←0.
- run is sampled only in IDLE and at end of shift. Dropping run mid‑shift never truncates a shift.
- LFSR: 15‑bit Fibonacci, polynomial x^15+x^14+1.
  - Advance: q ← {q[13:0], q[14]^q[13]}.
  - Period 32767.
  - lfsr_period=1 in the cycle after an advance that lands on LFSR_SEED.
  - With lfsr_en=0 the LFSR holds its state.
- pulse, shift_done and lfsr_period are registered outputs and glitch‑free. At most one pulse bit is high in any cycle.

## Timing
- Reset values:
  - state IDLE, p=0, pulse=0, gray=000, d_src=0
  - shift_done=0, lfsr_period=0, LFSR=LFSR_SEED, so lfsr_bit=LFSR_SEED[14]
- Assertion of rst_n=0 clears all outputs immediately, even mid‑shift. A truncated shift is not resumed.
- Latency: pulse[7] is high in the first cycle after the clock edge at which run=1 is sampled.
- Shift length: 8·(1+GAP_CYCLES) cycles. With GAP_CYCLES=1, a shift is 16 cycles.
- shift_done coincides with the last GAP cycle, or with the pulse[0] cycle when GAP_CYCLES=0.
- Continuous run with GAP_CYCLES=0: pulse[0] is followed directly by pulse[7], with no idle cycle between shifts.
- d_src is stable from the first pulse of a shift through pulse[0] of that shift.

## Structure
- Package hdsiso_pkg holds:
  - state enum {IDLE, PULSE, GAP}
  - LFSR_W=15, default seed, tap positions
  - PHASES=8
- Sub‑module hdsiso_lfsr15 (ports clk, rst_n, adv, bit, at_seed). The sequencer FSM, phase and gap counters, and the d_src register stay in hdsiso_phase_seq.

## Test plan
- Reset check: after reset release, all outputs equal the reset values. Hold run=0 for 20 cycles → pulse stays 0.
- Single shift, GAP_CYCLES=1: run high for one cycle.
  - pulse[7..0] asserted on cycles 1,3,…,15, in that order.
  - gray sequence 000,001,011,010,110,111,101,100.
  - shift_done on cycle 16, then IDLE.
- run dropped at cycle 5 of the second of continuous shifts → that shift completes (pulse[0] fires, shift_done) and no further pulse follows.
- rst_n asserted during pulse[4] → pulse=0 in the same cycle. After release, a shift restarts from pulse[7].
- din_sel=1, lfsr_en=1, continuous run for 32767 shifts:
  - lfsr_period fires exactly once, after shift 32767.
  - The d_src stream matches the reference polynomial model.
- GAP_CYCLES=0, din_sel=0, d_in toggled every cycle:
  - Pulses are back to back, one‑hot in every cycle.
  - d_src changes only at shift start.
